// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one prescaled edge/centre counter shared by CH duty comparators.
// Duty writes land in per-channel shadows and are committed, with the counting mode, at the period boundary.
module pwm_multi_ch #(
  parameter int CH      = 4,
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   ena,
  input  logic                                   cfg_we,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
  input  logic [WIDTH-1:0]                       cfg_duty,
  input  logic [PRESC_W-1:0]                     prescale,
  input  logic                                   center_mode,
  output logic [CH-1:0]                          pwm_out,
  output logic                                   period_tick,
  output logic                                   update_pending
);

  localparam int                CH_W     = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0]  CNT_ZERO = {WIDTH{1'b0}};

  logic [PRESC_W-1:0] r_presc_cnt;
  logic [WIDTH-1:0]   r_cnt;
  logic               r_dir_down;
  logic               r_mode;
  logic [WIDTH-1:0]   r_shadow [CH];
  logic [WIDTH-1:0]   r_active [CH];
  logic [CH-1:0]      r_pending;
  logic [CH-1:0]      r_pwm_out;
  logic               r_period_tick;
  logic               r_update_pending;

  logic               w_tick;
  logic               w_boundary;
  logic [WIDTH-1:0]   w_cnt_nxt;
  logic               w_dir_nxt;
  logic [CH-1:0]      w_sel;
  logic [CH-1:0]      w_pending_nxt;

  // >= rather than == so lowering prescale mid-count never forces a long wrap
  assign w_tick = ena & (r_presc_cnt >= prescale);

  // An out-of-range cfg_ch matches no channel, so such writes fall away naturally
  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign w_sel[g]         = cfg_we & (cfg_ch == CH_W'(g));
    assign w_pending_nxt[g] = w_sel[g] | (r_pending[g] & ~w_boundary);
  end

  // Next counter value, direction and boundary detection for the current mode
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_dir_nxt  = r_dir_down;
    w_boundary = 1'b0;
    if (!w_tick) begin
      w_cnt_nxt = r_cnt;
    end else if (!r_mode) begin
      w_cnt_nxt  = r_cnt + CNT_ONE;
      w_boundary = (r_cnt == CNT_MAX);
    end else if (r_dir_down || (r_cnt == CNT_MAX)) begin
      w_cnt_nxt  = r_cnt - CNT_ONE;
      w_dir_nxt  = 1'b1;
      w_boundary = (r_cnt == CNT_ONE);
    end else begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end
    // Both modes sit at 0/up after a boundary, which also covers a restart on mode change
    if (w_boundary) begin
      w_cnt_nxt = CNT_ZERO;
      w_dir_nxt = 1'b0;
    end else begin
      w_dir_nxt = w_dir_nxt;
    end
  end

  // Prescaler, period counter and latched mode; all freeze while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc_cnt <= {PRESC_W{1'b0}};
      r_cnt       <= CNT_ZERO;
      r_dir_down  <= 1'b0;
      r_mode      <= 1'b0;
    end else if (ena) begin
      if (w_tick) begin
        r_presc_cnt <= {PRESC_W{1'b0}};
      end else begin
        r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
      end
      r_cnt      <= w_cnt_nxt;
      r_dir_down <= w_dir_nxt;
      if (w_boundary) begin
        r_mode <= center_mode;
      end else begin
        r_mode <= r_mode;
      end
    end else begin
      r_presc_cnt <= r_presc_cnt;
      r_cnt       <= r_cnt;
      r_dir_down  <= r_dir_down;
      r_mode      <= r_mode;
    end
  end

  // Shadow/active duty double buffer; the boundary copies the pre-write shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        r_shadow[i] <= CNT_ZERO;
        r_active[i] <= CNT_ZERO;
      end
      r_pending <= {CH{1'b0}};
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (w_sel[i]) begin
          r_shadow[i] <= cfg_duty;
        end else begin
          r_shadow[i] <= r_shadow[i];
        end
        if (w_boundary) begin
          r_active[i] <= r_shadow[i];
        end else begin
          r_active[i] <= r_active[i];
        end
      end
      r_pending <= w_pending_nxt;
    end
  end

  // Registered outputs: compare uses the counter value before this edge's update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_out        <= {CH{1'b0}};
      r_period_tick    <= 1'b0;
      r_update_pending <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        r_pwm_out[i] <= ena & (r_cnt < r_active[i]);
      end
      r_period_tick    <= w_boundary;
      r_update_pending <= |w_pending_nxt;
    end
  end

  assign pwm_out        = r_pwm_out;
  assign period_tick    = r_period_tick;
  assign update_pending = r_update_pending;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: a period-phase reference model checked every clock, plus directed duty/period checks.
`timescale 1ns/1ps
module tb_pwm_multi_ch;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int PW = 8;
  localparam int TOP = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [W-1:0]  cfg_duty;
  logic [PW-1:0] prescale;
  logic          center_mode;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
  logic          update_pending;
  logic [2:0]    pwm3;
  logic          tick3;
  logic          upd3;

  always #5 clk = ~clk;

  pwm_multi_ch #(.CH(CH), .WIDTH(W), .PRESC_W(PW)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_duty(cfg_duty), .prescale(prescale), .center_mode(center_mode),
    .pwm_out(pwm_out), .period_tick(period_tick), .update_pending(update_pending)
  );

  // Three-channel instance that only ever sees writes to the nonexistent channel 3
  pwm_multi_ch #(.CH(3), .WIDTH(W), .PRESC_W(PW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_ch(2'd3),
    .cfg_duty(cfg_duty), .prescale(prescale), .center_mode(center_mode),
    .pwm_out(pwm3), .period_tick(tick3), .update_pending(upd3)
  );

  int checks = 0;
  int failures = 0;
  int hi [CH];
  int n, n2;

  // Reference model: ticks since period start instead of an explicit up/down counter
  int            m_pc, m_phase;
  bit            m_mode;
  int            m_shadow [CH];
  int            m_active [CH];
  bit            m_pend [CH];
  logic [CH-1:0] m_pwm;
  bit            m_tick, m_upd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int period_len(input bit mode);
    return mode ? 2 * TOP : TOP + 1;
  endfunction

  function automatic int cnt_at(input bit mode, input int ph);
    if (!mode) return ph;
    return (ph <= TOP) ? ph : 2 * TOP - ph;
  endfunction

  function automatic bit next_is_boundary();
    return ena && (m_pc >= int'(prescale)) && (m_phase == period_len(m_mode) - 1);
  endfunction

  task automatic model_reset();
    m_pc = 0; m_phase = 0; m_mode = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_shadow[i] = 0; m_active[i] = 0; m_pend[i] = 1'b0;
    end
    m_pwm = '0; m_tick = 1'b0; m_upd = 1'b0;
  endtask

  task automatic model_step();
    bit tk, bnd;
    int c;
    c = cnt_at(m_mode, m_phase);
    for (int i = 0; i < CH; i++) m_pwm[i] = ena && (c < m_active[i]);
    tk  = ena && (m_pc >= int'(prescale));
    bnd = tk && (m_phase == period_len(m_mode) - 1);
    if (ena) m_pc = tk ? 0 : m_pc + 1;
    if (bnd) begin
      for (int i = 0; i < CH; i++) begin
        m_active[i] = m_shadow[i];
        m_pend[i] = 1'b0;
      end
      m_mode = center_mode;
      m_phase = 0;
    end else if (tk) begin
      m_phase++;
    end
    if (cfg_we && int'(cfg_ch) < CH) begin
      m_shadow[cfg_ch] = int'(cfg_duty);
      m_pend[cfg_ch] = 1'b1;
    end
    m_tick = bnd;
    m_upd = 1'b0;
    for (int i = 0; i < CH; i++) m_upd |= m_pend[i];
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("cyc", {pwm_out, period_tick, update_pending, pwm3, upd3},
             {m_pwm, m_tick, m_upd, 3'b000, 1'b0});
    for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
  endtask

  task automatic wr(input int ch, input int d);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_duty = W'(d);
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic clear_hi();
    for (int i = 0; i < CH; i++) hi[i] = 0;
  endtask

  task automatic wait_tick(input int budget, output int cnt);
    cnt = 0;
    do begin
      cycle();
      cnt++;
    end while (!period_tick && cnt < budget);
    check_eq("tick_seen", period_tick, 1'b1);
  endtask

  initial begin
    int edge_duty [CH];
    int k;
    edge_duty = '{170, 0, 255, 1};
    rst_n = 1'b0; ena = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_duty = '0;
    prescale = '0; center_mode = 1'b0;
    clear_hi();
    model_reset();

    // Reset held for 5 clocks
    repeat (5) begin
      @(posedge clk); #1;
      check_eq("rst_pwm", pwm_out, '0);
      check_eq("rst_tick", period_tick, 1'b0);
      check_eq("rst_pend", update_pending, 1'b0);
    end
    rst_n = 1'b1;
    ena = 1'b1;
    repeat (300) cycle();
    check_eq("idle_pwm", pwm_out, '0);

    // Edge mode, prescale 0
    for (int i = 0; i < CH; i++) wr(i, edge_duty[i]);
    check_eq("wr_pend", update_pending, 1'b1);
    wait_tick(600, n);
    check_eq("apply_pend", update_pending, 1'b0);
    clear_hi();
    repeat (256) cycle();
    for (int i = 0; i < CH; i++) check_eq("edge_hi", 64'(hi[i]), 64'(edge_duty[i]));

    // Double buffer: mid-period write does not disturb the running period
    clear_hi();
    repeat (100) cycle();
    wr(0, 64);
    check_eq("dbuf_pend", update_pending, 1'b1);
    repeat (155) cycle();
    check_eq("dbuf_old_hi", 64'(hi[0]), 64'd170);
    check_eq("dbuf_tick", period_tick, 1'b1);
    check_eq("dbuf_pend_clr", update_pending, 1'b0);
    clear_hi();
    repeat (256) cycle();
    check_eq("dbuf_new_hi", 64'(hi[0]), 64'd64);

    // Prescale 3
    prescale = 8'd3;
    wr(0, 170);
    wait_tick(2000, n);
    wait_tick(2000, n);
    clear_hi();
    wait_tick(2000, n);
    check_eq("p3_spacing", 64'(n), 64'd1024);
    check_eq("p3_hi", 64'(hi[0]), 64'd680);

    // Centre-aligned mode
    prescale = 8'd0;
    center_mode = 1'b1;
    wr(0, 64);
    wait_tick(2000, n);
    clear_hi();
    wait_tick(1200, n);
    check_eq("ctr_period", 64'(n), 64'd510);
    check_eq("ctr_hi", 64'(hi[0]), 64'd127);
    k = 0;
    while (!next_is_boundary() && k < 1200) begin
      cycle();
      k++;
    end
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_duty = 8'd32;
    cycle();
    cfg_we = 1'b0;
    check_eq("bwr_tick", period_tick, 1'b1);
    check_eq("bwr_pend", update_pending, 1'b1);
    clear_hi();
    wait_tick(1200, n);
    check_eq("bwr_old_hi", 64'(hi[0]), 64'd127);
    clear_hi();
    wait_tick(1200, n);
    check_eq("bwr_new_hi", 64'(hi[0]), 64'd63);

    // ena low for 50 clocks shifts the next boundary by 50
    center_mode = 1'b0;
    wait_tick(1200, n);
    wait_tick(600, n);
    repeat (100) cycle();
    ena = 1'b0;
    repeat (50) cycle();
    check_eq("ena0_pwm", pwm_out, '0);
    ena = 1'b1;
    wait_tick(600, n2);
    check_eq("ena0_shift", 64'(150 + n2), 64'd306);

    // Asynchronous reset mid-period discards pending shadow data
    repeat (10) cycle();
    wr(1, 99);
    repeat (5) cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("arst_pwm", pwm_out, '0);
    check_eq("arst_tick", period_tick, 1'b0);
    check_eq("arst_pend", update_pending, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_tick(600, n);
    clear_hi();
    wait_tick(600, n);
    check_eq("arst_discard", 64'(hi[1]), 64'd0);

    // Randomised traffic against the model
    for (int it = 0; it < 30; it++) begin
      int len;
      ena = ($urandom_range(0, 9) != 0);
      prescale = PW'($urandom_range(0, 2));
      center_mode = 1'($urandom_range(0, 1));
      len = $urandom_range(100, 700);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 15) == 0) wr($urandom_range(0, CH - 1), $urandom_range(0, TOP));
        else cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
